// File: rtl/demux_dispatcher.sv
// Registered valid/ready 1-to-N dispatcher with a per-word stall timeout.
// Define DEMUX_DISPATCH_RR_EN to pick lanes round-robin instead of from `s`.
module demux_dispatcher #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int TMO = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [W-1:0]         i,
  input  logic [$clog2(N)-1:0] s,
  output logic [N*W-1:0]       y,
  output logic [N-1:0]         y_valid,
  input  logic [N-1:0]         y_ready,
  output logic                 err,
  output logic                 busy
);

  localparam int SW = $clog2(N);
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TMO);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SW-1:0]   dst_q, dst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [SW-1:0]   load_dst;
  logic            dst_ready;
  logic            accept;

`ifdef DEMUX_DISPATCH_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          unused_s;

  assign unused_s = ^s;
  assign load_dst = ptr_q;
`else
  assign load_dst = s;
`endif

  // Only the selected lane's ready matters; the others are ignored.
  assign dst_ready = y_ready[dst_q];
  assign i_ready   = !rst && ((state_q == IDLE) || dst_ready);
  assign accept    = i_valid && i_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    data_d  = data_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef DEMUX_DISPATCH_RR_EN
    ptr_d   = ptr_q;
`endif
    if (accept) begin
      state_d = HOLD;
      data_d  = i;
      dst_d   = load_dst;
      cnt_d   = '0;
`ifdef DEMUX_DISPATCH_RR_EN
      ptr_d   = ptr_q + SW'(1);
`endif
    end else if (state_q == HOLD) begin
      if (dst_ready) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if ((TMO > 0) && (cnt_q == TMO_LAST)) begin
        // Transfer wins over timeout: this branch is only reached with the lane stalled.
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else if (cnt_q != TMO_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the data register is reset too so y is a clean 0 out of reset.
      data_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef DEMUX_DISPATCH_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Outputs decode only registered state, so they carry no input-to-output path.
  always_comb begin
    y       = '0;
    y_valid = '0;
    if (state_q == HOLD) begin
      y[dst_q*W +: W] = data_q;
      y_valid[dst_q]  = 1'b1;
    end
  end

  assign err  = err_q;
  assign busy = (state_q == HOLD);

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: stimulus pushes expected words,
// a negedge monitor pops them on every lane handshake or timeout drop.
module tb_demux_dispatcher;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid;
  logic           i_ready;
  logic [W-1:0]   i;
  logic [1:0]     s;
  logic [N*W-1:0] y;
  logic [N-1:0]   y_valid;
  logic [N-1:0]   y_ready;
  logic           err;
  logic           busy;

  typedef struct {
    logic [1:0]   lane;
    logic [W-1:0] data;
    bit           drop;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  logic [1:0] rr_ptr = 2'd0;

  demux_dispatcher #(.W(W), .N(N), .TMO(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i       (i),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane the DUT should pick for selector sel; mirrors the chosen build.
  function automatic logic [1:0] pick_lane(input logic [1:0] sel);
`ifdef DEMUX_DISPATCH_RR_EN
    pick_lane = rr_ptr;
    rr_ptr    = rr_ptr + 2'd1;
`else
    pick_lane = sel;
`endif
  endfunction

  // Present a word for one cycle (caller steps the clock) and record what it should do.
  task automatic offer(input logic [W-1:0] d, input logic [1:0] sel, input bit drop,
                       output logic [1:0] lane);
    exp_t e;
    i_valid = 1'b1;
    i       = d;
    s       = sel;
    lane    = pick_lane(sel);
    e.lane  = lane;
    e.data  = d;
    e.drop  = drop;
    sb.push_back(e);
  endtask

  // Monitor: one pop per handshake or per err pulse.
  always @(negedge clk) begin
    exp_t e;
    logic [N*W-1:0] ey;
    if (!rst) begin
      if (|(y_valid & y_ready)) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_xfer: y_valid=%b y=0x%0h with empty scoreboard", y_valid, y);
        end else begin
          e  = sb.pop_front();
          ey = {{(N*W-W){1'b0}}, e.data} << (32'(e.lane) * W);
          check("xfer_not_drop", 64'(e.drop), 64'(0));
          check("xfer_y_valid", 64'(y_valid), 64'(4'b0001 << e.lane));
          check("xfer_y", 64'(y), 64'(ey));
        end
      end
      if (err) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_err: err pulse with empty scoreboard at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("drop_expected", 64'(e.drop), 64'(1));
          check("drop_busy", 64'(busy), 64'(0));
        end
      end
    end
  end

  initial begin
    logic [1:0] lane;
    int vcnt, rcnt, ecnt, ecyc;
    logic [W-1:0] bb_data [3];
    logic [1:0]   bb_sel  [3];
    bb_data = '{8'h11, 8'h22, 8'h33};
    bb_sel  = '{2'd0, 2'd1, 2'd3};

    rst     = 1'b1;
    i_valid = 1'b0;
    i       = '0;
    s       = '0;
    y_ready = '0;

    // Reset state
    @(negedge clk);
    check("rst_y_valid", 64'(y_valid), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_i_ready", 64'(i_ready), 64'(0));
    step();
    rst = 1'b0;

    // Addressed dispatch: 0xA5 to lane 2
    offer(8'hA5, 2'd2, 1'b0, lane);
    y_ready = 4'b0001 << lane;
    @(negedge clk);
    check("t1_i_ready_idle", 64'(i_ready), 64'(1));
    check("t1_busy_idle", 64'(busy), 64'(0));
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("t1_busy_hold", 64'(busy), 64'(1));
    check("t1_y_valid", 64'(y_valid), 64'(4'b0001 << lane));
    step();
    @(negedge clk);
    check("t1_back_idle", 64'(busy), 64'(0));
    check("t1_y_idle", 64'(y), 64'(0));
    step();

    // Back-to-back to lanes 0, 1, 3 with all lanes ready
    y_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      offer(bb_data[k], bb_sel[k], 1'b0, lane);
      @(negedge clk);
      check("bb_i_ready", 64'(i_ready), 64'(1));
      step();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("bb_last_busy", 64'(busy), 64'(1));
    step();
    @(negedge clk);
    check("bb_done_idle", 64'(busy), 64'(0));
    step();

    // Stall 5 cycles on lane 1 then release
    y_ready = 4'b0000;
    offer(8'h5A, 2'd1, 1'b0, lane);
    step();
    i_valid = 1'b0;
    vcnt = 0; rcnt = 0; ecnt = 0;
    for (int c = 0; c < 6; c++) begin
      y_ready = (c < 5) ? 4'b0000 : (4'b0001 << lane);
      @(negedge clk);
      if (y_valid[lane]) vcnt++;
      if (!i_ready) rcnt++;
      if (err) ecnt++;
      step();
    end
    @(negedge clk);
    if (err) ecnt++;
    check("stall_valid_cycles", 64'(vcnt), 64'(6));
    check("stall_not_ready_cycles", 64'(rcnt), 64'(5));
    check("stall_no_err", 64'(ecnt), 64'(0));
    check("stall_idle", 64'(busy), 64'(0));
    step();

    // Timeout: lane never ready -> 15 visible cycles, err on the 16th
    y_ready = 4'b0000;
    offer(8'hC3, 2'd3, 1'b1, lane);
    step();
    i_valid = 1'b0;
    vcnt = 0; ecnt = 0; ecyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (y_valid[lane]) vcnt++;
      if (err) begin
        ecnt++;
        ecyc = c;
      end
      step();
    end
    check("tmo_valid_cycles", 64'(vcnt), 64'(15));
    check("tmo_err_pulses", 64'(ecnt), 64'(1));
    check("tmo_err_cycle", 64'(ecyc), 64'(15));

    // Timeout edge: ready rises in the 15th cycle -> transfer, no err
    offer(8'hD4, 2'd0, 1'b0, lane);
    step();
    i_valid = 1'b0;
    vcnt = 0; ecnt = 0;
    for (int c = 0; c < 20; c++) begin
      y_ready = (c == 14) ? (4'b0001 << lane) : 4'b0000;
      @(negedge clk);
      if (y_valid[lane]) vcnt++;
      if (err) ecnt++;
      step();
    end
    check("tmo_edge_valid_cycles", 64'(vcnt), 64'(15));
    check("tmo_edge_no_err", 64'(ecnt), 64'(0));

    // Async reset mid-HOLD: held word is discarded, not dropped with err
    y_ready = 4'b0000;
    i_valid = 1'b1;
    i       = 8'hE7;
    s       = 2'd2;
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("ar_busy_before", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("ar_y_valid", 64'(y_valid), 64'(0));
    check("ar_y", 64'(y), 64'(0));
    check("ar_err", 64'(err), 64'(0));
    check("ar_busy", 64'(busy), 64'(0));
    check("ar_i_ready", 64'(i_ready), 64'(0));
    rr_ptr = 2'd0;
    step();
    rst = 1'b0;
    offer(8'hF0, 2'd1, 1'b0, lane);
    y_ready = 4'b0001 << lane;
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("ar_resume_y_valid", 64'(y_valid), 64'(4'b0001 << lane));
    step();
    for (int c = 0; c < 18; c++) step();

`ifdef DEMUX_DISPATCH_RR_EN
    // Round-robin from a fresh reset: s fixed at 3, lanes must be 0,1,2,3,0,1
    rst = 1'b1;
    step();
    rst    = 1'b0;
    rr_ptr = 2'd0;
    y_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      offer(8'h60 + 8'(k), 2'd3, 1'b0, lane);
      check("rr_lane", 64'(lane), 64'(k % 4));
      step();
    end
    i_valid = 1'b0;
    step();
    step();
`endif

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
